// File: rtl/nes_video_pkg.sv
// Shared types and constants for the Pocket video output formatter.
package nes_video_pkg;

    localparam int CNT_W    = 9;
    localparam int SLOT_LSB = 13;

    typedef enum logic [1:0] {
        WAIT_VS,
        FIRST_FRAME,
        TRACKING
    } geom_state_e;

    // Saturating increment; holds at lim once reached.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Pixel-enable gated rising-edge detector for a sync input.
module sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ce,
    input  logic i_sig,
    output logic o_rise
);

    logic r_hist;

    // History resets high so a sync already asserted at reset release gives no strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hist <= 1'b1;
        end else if (i_ce) begin
            r_hist <= i_sig;
        end
    end

    assign o_rise = i_ce & i_sig & ~r_hist;

endmodule

// File: rtl/nes_apf_video_out.sv
// Formats the NES pixel stream for the Analogue Pocket scaler and tracks active geometry.
module nes_apf_video_out
    import nes_video_pkg::*;
#(
    parameter int unsigned MAX_X = 511,
    parameter int unsigned MAX_Y = 511
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_pix,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        hblank,
    input  logic        vblank,
    input  logic [2:0]  scaler_slot,
    output logic [23:0] video_rgb,
    output logic        video_de,
    output logic        video_hs,
    output logic        video_vs,
    output logic [8:0]  active_w,
    output logic [8:0]  active_h,
    output logic        geom_stable
);

    localparam logic [CNT_W-1:0] X_SAT = CNT_W'(MAX_X);
    localparam logic [CNT_W-1:0] Y_SAT = CNT_W'(MAX_Y);

    logic w_de_in;
    logic w_de_fall;
    logic w_hs_rise;
    logic w_vs_rise;

    logic             r_de_prev;
    logic [23:0]      r_rgb;
    logic             r_de;
    logic             r_hs;
    logic             r_vs;
    logic             r_hs_pending;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic [CNT_W-1:0] r_active_w;
    logic [CNT_W-1:0] r_active_h;
    logic [CNT_W-1:0] r_prev_w;
    logic [CNT_W-1:0] r_prev_h;
    logic             r_geom_stable;
    geom_state_e      r_state;

    assign w_de_in   = ~hblank & ~vblank;
    assign w_de_fall = r_de_prev & ~w_de_in;

    sync_edge u_hs_edge (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_ce    (ce_pix),
        .i_sig   (hsync),
        .o_rise  (w_hs_rise)
    );

    sync_edge u_vs_edge (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_ce    (ce_pix),
        .i_sig   (vsync),
        .o_rise  (w_vs_rise)
    );

    // Pixel data and DE; the slot word fills the first blank pixel after an active run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_de_prev <= 1'b0;
            r_de      <= 1'b0;
            r_rgb     <= '0;
        end else if (ce_pix) begin
            r_de_prev <= w_de_in;
            r_de      <= w_de_in;
            if (w_de_in) begin
                r_rgb <= {r, g, b};
            end else if (w_de_fall) begin
                r_rgb <= 24'(scaler_slot) << SLOT_LSB;
            end else begin
                r_rgb <= '0;
            end
        end
    end

    // Sync strobes; a coincident HS is deferred one pixel so HS and VS never overlap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs         <= 1'b0;
            r_vs         <= 1'b0;
            r_hs_pending <= 1'b0;
        end else if (ce_pix) begin
            r_vs <= w_vs_rise;
            if (w_vs_rise) begin
                r_hs         <= 1'b0;
                r_hs_pending <= r_hs_pending | w_hs_rise;
            end else begin
                r_hs         <= w_hs_rise | r_hs_pending;
                r_hs_pending <= 1'b0;
            end
        end
    end

    // Active pixel and line counters; VS clears the line count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_active_w <= '0;
        end else if (ce_pix) begin
            if (w_de_in) begin
                r_x <= sat_inc(r_x, X_SAT);
            end else if (w_de_fall) begin
                r_active_w <= r_x;
                r_x        <= '0;
            end
            if (w_vs_rise) begin
                r_y <= '0;
            end else if (w_de_fall) begin
                r_y <= sat_inc(r_y, Y_SAT);
            end
        end
    end

    // Geometry FSM: first VS only aligns, second captures, later ones compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= WAIT_VS;
            r_active_h    <= '0;
            r_prev_w      <= '0;
            r_prev_h      <= '0;
            r_geom_stable <= 1'b0;
        end else if (w_vs_rise) begin
            case (r_state)
                WAIT_VS: begin
                    r_state <= FIRST_FRAME;
                end
                FIRST_FRAME: begin
                    r_active_h    <= r_y;
                    r_prev_w      <= r_active_w;
                    r_prev_h      <= r_y;
                    r_geom_stable <= 1'b0;
                    r_state       <= TRACKING;
                end
                TRACKING: begin
                    r_active_h    <= r_y;
                    r_prev_w      <= r_active_w;
                    r_prev_h      <= r_y;
                    r_geom_stable <= ({r_active_w, r_y} == {r_prev_w, r_prev_h});
                end
                default: begin
                    r_state       <= WAIT_VS;
                    r_geom_stable <= 1'b0;
                end
            endcase
        end
    end

    assign video_rgb   = r_rgb;
    assign video_de    = r_de;
    assign video_hs    = r_hs;
    assign video_vs    = r_vs;
    assign active_w    = r_active_w;
    assign active_h    = r_active_h;
    assign geom_stable = r_geom_stable;

endmodule

// File: tb/tb_nes_apf_video_out.sv
// Scoreboard bench for nes_apf_video_out: per-pixel output words plus geometry checkpoints.
module tb_nes_apf_video_out;
    import nes_video_pkg::*;

    localparam int W  = 16;
    localparam int H1 = 24;
    localparam int H2 = 20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce_pix;
    logic [7:0]  r, g, b;
    logic        hsync, vsync, hblank, vblank;
    logic [2:0]  scaler_slot;
    logic [23:0] video_rgb;
    logic        video_de, video_hs, video_vs;
    logic [8:0]  active_w, active_h;
    logic        geom_stable;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } px_t;

    px_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model state for the per-pixel output word.
    logic m_prev_h, m_prev_v, m_prev_de, m_pend;

    always #5 clk = ~clk;

    nes_apf_video_out dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce_pix      (ce_pix),
        .r           (r),
        .g           (g),
        .b           (b),
        .hsync       (hsync),
        .vsync       (vsync),
        .hblank      (hblank),
        .vblank      (vblank),
        .scaler_slot (scaler_slot),
        .video_rgb   (video_rgb),
        .video_de    (video_de),
        .video_hs    (video_hs),
        .video_vs    (video_vs),
        .active_w    (active_w),
        .active_h    (active_h),
        .geom_stable (geom_stable)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_h  = 1'b1;
        m_prev_v  = 1'b1;
        m_prev_de = 1'b0;
        m_pend    = 1'b0;
    endtask

    // One pixel period: drive, push expectation, let the ce edge pass, pop and compare.
    task automatic pix(input logic h, input logic v, input logic hb, input logic vb,
                       input logic [23:0] rgb);
        px_t  e;
        px_t  o;
        logic de, hr, vr;
        @(negedge clk);
        hsync = h;
        vsync = v;
        hblank = hb;
        vblank = vb;
        {r, g, b} = rgb;
        ce_pix = 1'b1;
        de = ~hb & ~vb;
        hr = h & ~m_prev_h;
        vr = v & ~m_prev_v;
        e.de  = de;
        e.rgb = de ? rgb : (m_prev_de ? {8'h00, scaler_slot, 13'h0000} : 24'h000000);
        e.vs  = vr;
        if (vr) begin
            e.hs   = 1'b0;
            m_pend = m_pend | hr;
        end else begin
            e.hs   = hr | m_pend;
            m_pend = 1'b0;
        end
        m_prev_h  = h;
        m_prev_v  = v;
        m_prev_de = de;
        sb_q.push_back(e);
        @(negedge clk);
        ce_pix = 1'b0;
        o = {video_de, video_hs, video_vs, video_rgb};
        check("px", 32'(o), 32'(sb_q.pop_front()));
        repeat (2) @(negedge clk);
    endtask

    task automatic line(input int n, input logic [23:0] base, input bit rnd);
        repeat (2) pix(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
        for (int i = 0; i < n; i++) begin
            pix(1'b0, 1'b0, 1'b0, 1'b0, rnd ? 24'($urandom) : base);
        end
        repeat (2) pix(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
        repeat (2) pix(1'b1, 1'b0, 1'b1, 1'b0, 24'h0);
        repeat (2) pix(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
    endtask

    task automatic vbl();
        repeat (3) pix(1'b0, 1'b0, 1'b1, 1'b1, 24'h0);
        repeat (2) pix(1'b0, 1'b1, 1'b1, 1'b1, 24'h0);
        repeat (3) pix(1'b0, 1'b0, 1'b1, 1'b1, 24'h0);
    endtask

    task automatic frame(input int h);
        for (int l = 0; l < h; l++) begin
            line(W, 24'h0, 1'b1);
        end
        vbl();
    endtask

    initial begin
        reset_n = 1'b0;
        ce_pix = 1'b0;
        hsync = 1'b0;
        vsync = 1'b1;
        hblank = 1'b1;
        vblank = 1'b1;
        {r, g, b} = 24'h0;
        scaler_slot = 3'd5;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rgb", 32'(video_rgb), 0);
        check("rst_de", 32'(video_de), 0);
        check("rst_vs", 32'(video_vs), 0);
        reset_n = 1'b1;

        // vsync held high through reset release must not strobe
        repeat (10) pix(1'b0, 1'b1, 1'b1, 1'b1, 24'h0);
        check("hold_vs", 32'(video_vs), 0);
        check("hold_state", 32'(dut.r_state), 32'(WAIT_VS));
        check("hold_aw", 32'(active_w), 0);
        check("hold_ah", 32'(active_h), 0);
        check("hold_geom", 32'(geom_stable), 0);

        // 256-pixel line followed by the slot word
        repeat (2) pix(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
        for (int i = 0; i < 256; i++) pix(1'b0, 1'b0, 1'b0, 1'b0, 24'h123456);
        check("line_de", 32'(video_de), 1);
        check("line_rgb", 32'(video_rgb), 32'h123456);
        pix(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
        check("slot_rgb", 32'(video_rgb), 32'h00A000);
        check("slot_de", 32'(video_de), 0);
        check("aw_256", 32'(active_w), 256);
        pix(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
        check("post_slot_rgb", 32'(video_rgb), 0);

        // coincident hsync/vsync rise: VS first, HS one pixel later
        pix(1'b0, 1'b0, 1'b1, 1'b1, 24'h0);
        pix(1'b1, 1'b1, 1'b1, 1'b1, 24'h0);
        check("coinc_vs", 32'(video_vs), 1);
        check("coinc_hs", 32'(video_hs), 0);
        check("vs1_state", 32'(dut.r_state), 32'(FIRST_FRAME));
        pix(1'b1, 1'b1, 1'b1, 1'b1, 24'h0);
        check("defer_hs", 32'(video_hs), 1);
        check("defer_vs", 32'(video_vs), 0);
        pix(1'b0, 1'b0, 1'b1, 1'b1, 24'h0);
        check("defer_hs_end", 32'(video_hs), 0);

        frame(H1);
        check("vs2_ah", 32'(active_h), H1);
        check("vs2_geom", 32'(geom_stable), 0);
        check("vs2_state", 32'(dut.r_state), 32'(TRACKING));
        scaler_slot = 3'd3;
        frame(H1);
        check("vs3_ah", 32'(active_h), H1);
        check("vs3_geom", 32'(geom_stable), 1);
        frame(H2);
        check("vs4_ah", 32'(active_h), H2);
        check("vs4_geom", 32'(geom_stable), 0);
        frame(H2);
        check("vs5_geom", 32'(geom_stable), 1);

        // x saturation
        line(600, 24'h0, 1'b1);
        check("aw_sat", 32'(active_w), 511);
        check("sat_geom", 32'(geom_stable), 1);

        // asynchronous reset mid-line
        repeat (2) pix(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
        for (int i = 0; i < 100; i++) pix(1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom));
        check("pre_rst_de", 32'(video_de), 1);
        #2;
        reset_n = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        hblank = 1'b1;
        vblank = 1'b1;
        #1;
        check("mid_rst_de", 32'(video_de), 0);
        check("mid_rst_rgb", 32'(video_rgb), 0);
        check("mid_rst_geom", 32'(geom_stable), 0);
        check("mid_rst_aw", 32'(active_w), 0);
        check("mid_rst_ah", 32'(active_h), 0);
        check("mid_rst_state", 32'(dut.r_state), 32'(WAIT_VS));
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        repeat (4) pix(1'b1, 1'b1, 1'b1, 1'b1, 24'h0);
        check("rel_vs", 32'(video_vs), 0);
        check("rel_hs", 32'(video_hs), 0);
        pix(1'b0, 1'b0, 1'b1, 1'b1, 24'h0);
        vbl();
        check("r_vs1_state", 32'(dut.r_state), 32'(FIRST_FRAME));
        check("r_vs1_geom", 32'(geom_stable), 0);
        frame(H1);
        check("r_vs2_ah", 32'(active_h), H1);
        check("r_vs2_geom", 32'(geom_stable), 0);
        frame(H1);
        check("r_vs3_geom", 32'(geom_stable), 1);

        check("sb_drain", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
